// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU encodings, control-word layout and FSM states
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int CW_MEMREAD  = 8;
  localparam int CW_MEMWRITE = 7;
  localparam int CW_ALUSRC   = 6;
  localparam int CW_REGDST   = 5;
  localparam int CW_ALUOP_HI = 4;
  localparam int CW_ALUOP_LO = 2;
  localparam int CW_MEMTOREG = 1;
  localparam int CW_REGWRITE = 0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  function automatic logic [8:0] make_ctrl(
    input logic       memread,
    input logic       memwrite,
    input logic       alusrc,
    input logic       regdst,
    input logic [2:0] aluop,
    input logic       memtoreg,
    input logic       regwrite
  );
    return {memread, memwrite, alusrc, regdst, aluop, memtoreg, regwrite};
  endfunction

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// rtl/mips_hazard_ctrl_if.sv - datapath <-> hazard/control unit signal bundle
interface mips_hazard_ctrl_if;
  logic [31:0] instr_id;
  logic        eq_id;
  logic [4:0]  rs_ex;
  logic [4:0]  rt_ex;
  logic [4:0]  rd_mem;
  logic        regwrite_mem;
  logic [4:0]  rd_wb;
  logic        regwrite_wb;
  logic [8:0]  ctrl_word;
  logic        hazard_sel;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        pc_src;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall_active;

  modport master (
    output instr_id, eq_id, rs_ex, rt_ex, rd_mem, regwrite_mem, rd_wb, regwrite_wb,
    input  ctrl_word, hazard_sel, pc_write, if_id_write, if_id_flush, pc_src,
           forward_a, forward_b, stall_active
  );

  modport slave (
    input  instr_id, eq_id, rs_ex, rt_ex, rd_mem, regwrite_mem, rd_wb, regwrite_wb,
    output ctrl_word, hazard_sel, pc_write, if_id_write, if_id_flush, pc_src,
           forward_a, forward_b, stall_active
  );
endinterface

// File: rtl/mips_main_decoder.sv
// rtl/mips_main_decoder.sv - combinational opcode/funct to 9-bit stage control word
module mips_main_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [8:0] ctrl_word
);

  always_comb begin
    ctrl_word = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  ctrl_word = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b1);
          FN_SUB:  ctrl_word = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB, 1'b0, 1'b1);
          FN_AND:  ctrl_word = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALU_AND, 1'b0, 1'b1);
          FN_OR:   ctrl_word = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALU_OR,  1'b0, 1'b1);
          FN_SLT:  ctrl_word = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALU_SLT, 1'b0, 1'b1);
          default: ctrl_word = '0;
        endcase
      end
      OP_LW:   ctrl_word = make_ctrl(1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD, 1'b1, 1'b1);
      OP_SW:   ctrl_word = make_ctrl(1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0);
      OP_ADDI: ctrl_word = make_ctrl(1'b0, 1'b0, 1'b1, 1'b1, ALU_ADD, 1'b0, 1'b1);
      OP_SLTI: ctrl_word = make_ctrl(1'b0, 1'b0, 1'b1, 1'b1, ALU_SLT, 1'b0, 1'b1);
      default: ctrl_word = '0;
    endcase
  end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// rtl/mips_hazard_ctrl.sv - pipeline control, load-use/branch stall FSM and EX forwarding
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int STALL_CNT_W = 2
) (
  input logic              clk,
  input logic              rst,
  mips_hazard_ctrl_if.slave hz
);

  logic [8:0]             dec_ctrl;
  logic [8:0]             issued;
  logic [4:0]             rs_id, rt_id, rd_id;
  logic                   is_beq, rt_used;
  logic                   load_use, beq_ex, beq_mem;
  logic [1:0]             need;
  logic                   stall, take_branch;
  hz_state_e              state, state_nx;
  logic [STALL_CNT_W-1:0] cnt, cnt_nx;
  logic                   ex_memread, ex_regwrite, mem_memread;
  logic [4:0]             ex_dst;
  logic                   unused_shamt;

  assign rs_id        = hz.instr_id[25:21];
  assign rt_id        = hz.instr_id[20:16];
  assign rd_id        = hz.instr_id[15:11];
  assign unused_shamt = ^hz.instr_id[10:6];

  mips_main_decoder u_dec (
    .opcode   (hz.instr_id[31:26]),
    .funct    (hz.instr_id[5:0]),
    .ctrl_word(dec_ctrl)
  );

  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  assign is_beq  = (hz.instr_id[31:26] == OP_BEQ);
  assign rt_used = (hz.instr_id[31:26] == OP_RTYPE) || (hz.instr_id[31:26] == OP_SW) || is_beq;

  // A beq compares in ID, so a producer still in EX/MEM must be waited on, not forwarded.
  always_comb begin
    load_use = ex_memread &&
               (reg_match(ex_dst, rs_id) || (rt_used && reg_match(ex_dst, rt_id)));
    beq_ex   = is_beq && ex_regwrite &&
               (reg_match(ex_dst, rs_id) || reg_match(ex_dst, rt_id));
    beq_mem  = is_beq && hz.regwrite_mem && mem_memread &&
               (reg_match(hz.rd_mem, rs_id) || reg_match(hz.rd_mem, rt_id));
    need = 2'd0;
    if (beq_ex && ex_memread)
      need = 2'd2;
    else if (load_use || beq_ex || beq_mem)
      need = 2'd1;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    stall       = 1'b0;
    take_branch = 1'b0;
    case (state)
      ST_RUN: begin
        if (need != 2'd0) begin
          stall = 1'b1;
          if (need == 2'd2) begin
            state_nx = ST_STALL;
            cnt_nx   = STALL_CNT_W'(1);
          end
        end else if (is_beq && hz.eq_id) begin
          take_branch = 1'b1;
        end
      end
      ST_STALL: begin
        stall = 1'b1;
        if (cnt == STALL_CNT_W'(1)) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - STALL_CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    hz.ctrl_word    = '0;
    hz.hazard_sel   = 1'b0;
    hz.pc_write     = 1'b0;
    hz.if_id_write  = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.pc_src       = 1'b0;
    hz.stall_active = 1'b0;
    hz.forward_a    = FWD_REG;
    hz.forward_b    = FWD_REG;
    if (!rst) begin
      hz.ctrl_word    = dec_ctrl;
      hz.hazard_sel   = !stall;
      hz.pc_write     = !stall;
      hz.if_id_write  = !stall;
      hz.stall_active = stall;
      hz.pc_src       = take_branch;
      hz.if_id_flush  = take_branch;
      if (hz.regwrite_mem && reg_match(hz.rd_mem, hz.rs_ex))
        hz.forward_a = FWD_MEM;
      else if (hz.regwrite_wb && reg_match(hz.rd_wb, hz.rs_ex))
        hz.forward_a = FWD_WB;
      if (hz.regwrite_mem && reg_match(hz.rd_mem, hz.rt_ex))
        hz.forward_b = FWD_MEM;
      else if (hz.regwrite_wb && reg_match(hz.rd_wb, hz.rt_ex))
        hz.forward_b = FWD_WB;
    end
  end

  assign issued = hz.hazard_sel ? dec_ctrl : 9'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      cnt         <= '0;
      ex_memread  <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_dst      <= 5'd0;
      mem_memread <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ex_memread  <= issued[CW_MEMREAD];
      ex_regwrite <= issued[CW_REGWRITE];
      ex_dst      <= issued[CW_REGDST] ? rt_id : rd_id;
      mem_memread <= ex_memread;
    end
  end

endmodule
